// File: rtl/vram_scheduler_if.sv
// rtl/vram_scheduler_if.sv - pixel FIFO and MIG user-port bundle for vram_scheduler
interface vram_scheduler_if;
  logic [127:0] pix_read;
  logic         pix_read_valid;
  logic         pix_read_ready;
  logic [127:0] pix_write;
  logic         pix_write_valid;
  logic         pix_write_ready;
  logic         mig_cmd_en;
  logic [2:0]   mig_cmd_instr;
  logic [5:0]   mig_cmd_bl;
  logic [29:0]  mig_cmd_byte_addr;
  logic         mig_cmd_full;
  logic         mig_wr_en;
  logic [127:0] mig_wr_data;
  logic [15:0]  mig_wr_mask;
  logic         mig_wr_full;
  logic         mig_rd_en;
  logic [127:0] mig_rd_data;
  logic         mig_rd_empty;

  modport master (
    output pix_read, pix_read_valid, input pix_read_ready,
    input pix_write, pix_write_valid, output pix_write_ready,
    output mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr, input mig_cmd_full,
    output mig_wr_en, mig_wr_data, mig_wr_mask, input mig_wr_full,
    output mig_rd_en, input mig_rd_data, mig_rd_empty
  );

  modport slave (
    input pix_read, pix_read_valid, output pix_read_ready,
    output pix_write, pix_write_valid, input pix_write_ready,
    input mig_cmd_en, mig_cmd_instr, mig_cmd_bl, mig_cmd_byte_addr, output mig_cmd_full,
    input mig_wr_en, mig_wr_data, mig_wr_mask, output mig_wr_full,
    input mig_rd_en, output mig_rd_data, mig_rd_empty
  );
endinterface

// File: rtl/vram_scheduler.sv
// rtl/vram_scheduler.sv - frame-based VRAM burst scheduler between pixel FIFOs and one MIG port
module vram_scheduler #(
  parameter int          BURST_LEN     = 32,
  parameter int          RD_FIFO_DEPTH = 64,
  parameter logic [29:0] FB_BASE       = 30'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic [23:0]       frame_bytes,
  vram_scheduler_if.master  bus,
  output logic              error
);
  localparam logic [23:0] BURST_BYTES = 24'(BURST_LEN * 16);
  localparam int          IW          = $clog2(RD_FIFO_DEPTH + BURST_LEN + 1);
  localparam logic [IW-1:0] RD_LIMIT  = IW'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [IW-1:0] BL_I      = IW'(BURST_LEN);
  localparam int          WW          = $clog2(BURST_LEN + 1);
  localparam logic [WW-1:0] BL_W      = WW'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_DATA, WR_CMD} state_t;

  state_t        state;
  logic [23:0]   rd_ptr, wr_ptr, frame_end;
  logic [IW-1:0] rd_inflight;
  logic [WW-1:0] words;
  logic          vs_q, vs_pending;

  logic [23:0] frame_rounded;
  logic [24:0] wr_next_end;
  logic        vs_rise, rd_accept, can_write, can_read;

  assign frame_rounded = frame_bytes - (frame_bytes % BURST_BYTES);
  assign wr_next_end   = {1'b0, wr_ptr} + {1'b0, BURST_BYTES};
  assign vs_rise       = vsync && !vs_q;
  assign rd_accept     = (state == RD_CMD) && !bus.mig_cmd_full;
  // Only write back data whose read burst has already been commanded, or we could wait forever.
  assign can_write     = (wr_ptr < frame_end) && bus.pix_write_valid && ({1'b0, rd_ptr} >= wr_next_end);
  assign can_read      = (rd_ptr < frame_end) && (rd_inflight <= RD_LIMIT);

  assign bus.pix_read        = bus.mig_rd_data;
  assign bus.pix_read_valid  = rst_n && !bus.mig_rd_empty;
  assign bus.mig_rd_en       = rst_n && !bus.mig_rd_empty && bus.pix_read_ready;
  assign bus.pix_write_ready = rst_n && (state == WR_DATA) && !bus.mig_wr_full && (words < BL_W);
  assign bus.mig_wr_en       = bus.pix_write_ready && bus.pix_write_valid;
  assign bus.mig_wr_data     = bus.pix_write;
  assign bus.mig_wr_mask     = 16'h0000;
  assign bus.mig_cmd_bl      = 6'(BURST_LEN - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                 <= IDLE;
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      frame_end             <= '0;
      rd_inflight           <= '0;
      words                 <= '0;
      vs_q                  <= 1'b0;
      vs_pending            <= 1'b0;
      error                 <= 1'b0;
      bus.mig_cmd_en        <= 1'b0;
      bus.mig_cmd_instr     <= 3'b000;
      bus.mig_cmd_byte_addr <= '0;
    end else begin
      vs_q        <= vsync;
      rd_inflight <= rd_inflight + (rd_accept ? BL_I : '0)
                     - ((bus.mig_rd_en && rd_inflight != '0) ? IW'(1) : '0);
      case (state)
        IDLE: begin
          if (enable) begin
            if (vs_pending) begin
              frame_end  <= frame_rounded;
              rd_ptr     <= '0;
              wr_ptr     <= '0;
              vs_pending <= 1'b0;
            end else if (can_write) begin
              state <= WR_DATA;
              words <= '0;
            end else if (can_read) begin
              state                 <= RD_CMD;
              bus.mig_cmd_en        <= 1'b1;
              bus.mig_cmd_instr     <= 3'b001;
              bus.mig_cmd_byte_addr <= FB_BASE + {6'b0, rd_ptr};
            end
          end
        end
        RD_CMD: begin
          if (!bus.mig_cmd_full) begin
            bus.mig_cmd_en <= 1'b0;
            rd_ptr         <= rd_ptr + BURST_BYTES;
            state          <= IDLE;
          end
        end
        WR_DATA: begin
          if (bus.mig_wr_en) begin
            if (words == BL_W - 1'b1) begin
              words                 <= '0;
              state                 <= WR_CMD;
              bus.mig_cmd_en        <= 1'b1;
              bus.mig_cmd_instr     <= 3'b000;
              bus.mig_cmd_byte_addr <= FB_BASE + {6'b0, wr_ptr};
            end else begin
              words <= words + 1'b1;
            end
          end
        end
        WR_CMD: begin
          if (!bus.mig_cmd_full) begin
            bus.mig_cmd_en <= 1'b0;
            wr_ptr         <= wr_ptr + BURST_BYTES;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // A new frame arriving before the current one is fully read and written back is an overrun.
      if (vs_rise) begin
        vs_pending <= 1'b1;
        if ((rd_ptr < frame_end) || (wr_ptr < frame_end)) error <= 1'b1;
      end
    end
  end
endmodule
